// File: rtl/opacc_pkg.sv
// Shared types and helpers for the opacc operand/result sequencer.
package opacc_pkg;

    // Sequencer phases: command wait, C load, accumulate, drain prime, drain.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DPRIME,
        DRAIN
    } opacc_seq_state_e;

    // Width of a counter that must hold the values 0..rows inclusive.
    function automatic int unsigned row_cnt_w(input int unsigned rows);
        return $clog2(rows + 1);
    endfunction

endpackage

// File: rtl/opacc_seq.sv
// opacc_seq: drives the opacc shift chain through C load, K accumulate
// beats and the row drain, presenting valid/ready streams on both sides.
module opacc_seq
    import opacc_pkg::*;
#(
    parameter int unsigned vl   = 4,
    parameter int unsigned ml   = 4,
    parameter int unsigned XLEN = 64,
    parameter int unsigned KW   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // tile command
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [KW-1:0]                 cmd_k,
    input  logic                          cmd_zero,
    // C row stream
    input  logic                          c_valid,
    output logic                          c_ready,
    input  logic [vl-1:0][XLEN-1:0]       c_data,
    // A/B operand streams
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [vl-1:0][XLEN-1:0]       a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [vl-1:0][XLEN-1:0]       b_data,
    // result row stream
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [vl-1:0][XLEN-1:0]       r_data,
    // accumulator control interface
    output logic                          acc_en_c,
    output logic                          acc_en_ab,
    output logic                          acc_issng_a,
    output logic                          acc_issng_b,
    output logic [vl-1:0][XLEN-1:0]       acc_vi_a,
    output logic [vl-1:0][XLEN-1:0]       acc_vi_b,
    output logic [vl-1:0][XLEN-1:0]       acc_vi_c,
    input  logic [vl-1:0][XLEN-1:0]       acc_vo_c,
    output logic                          busy
);

    localparam int unsigned RCW = row_cnt_w(ml);

    typedef logic [vl-1:0][XLEN-1:0] opacc_row_t;

    opacc_seq_state_e state, state_nxt;
    logic [RCW-1:0]   row_cnt, row_cnt_nxt;
    logic [KW-1:0]    k_cnt, k_cnt_nxt;
    logic             zero_q, zero_nxt;
    logic             ab_fire;

    // Operands are consumed only jointly, and only while accumulating.
    assign ab_fire = (state == MAC) && a_valid && b_valid;

    // Operand and result data pass through, forced to zero outside their phase.
    assign acc_vi_a = (state == MAC)   ? opacc_row_t'(a_data)   : '0;
    assign acc_vi_b = (state == MAC)   ? opacc_row_t'(b_data)   : '0;
    assign r_data   = (state == DRAIN) ? opacc_row_t'(acc_vo_c) : '0;
    assign busy     = (state != IDLE);

    // State, counters and latched command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
            k_cnt   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
            k_cnt   <= k_cnt_nxt;
            zero_q  <= zero_nxt;
        end
    end

    // Next-state, counter updates and all handshake/enable outputs.
    always_comb begin
        // NOTE: every value written here gets a default first so no path leaves a latch behind.
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        k_cnt_nxt   = k_cnt;
        zero_nxt    = zero_q;
        cmd_ready   = 1'b0;
        c_ready     = 1'b0;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        r_valid     = 1'b0;
        acc_en_c    = 1'b0;
        acc_en_ab   = 1'b0;
        acc_issng_a = 1'b0;
        acc_issng_b = 1'b0;
        acc_vi_c    = '0;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    k_cnt_nxt   = cmd_k;
                    zero_nxt    = cmd_zero;
                    row_cnt_nxt = RCW'(ml);
                    state_nxt   = LOAD;
                end
            end

            LOAD: begin
                if (zero_q) begin
                    acc_en_c = 1'b1;
                end else begin
                    c_ready  = 1'b1;
                    acc_en_c = c_valid;
                    acc_vi_c = c_data;
                end
                if (acc_en_c) begin
                    row_cnt_nxt = row_cnt - RCW'(1);
                    if (row_cnt == RCW'(1)) begin
                        state_nxt = (k_cnt != '0) ? MAC : DPRIME;
                    end
                end
            end

            MAC: begin
                a_ready     = ab_fire;
                b_ready     = ab_fire;
                acc_en_ab   = ab_fire;
                acc_issng_a = ab_fire;
                acc_issng_b = ab_fire;
                if (ab_fire) begin
                    k_cnt_nxt = k_cnt - KW'(1);
                    if (k_cnt == KW'(1)) begin
                        state_nxt = DPRIME;
                    end
                end
            end

            // Shift the bottom row into the accumulator output register so
            // DRAIN can present it immediately.
            DPRIME: begin
                acc_en_c    = 1'b1;
                row_cnt_nxt = RCW'(ml - 1);
                state_nxt   = DRAIN;
            end

            DRAIN: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    if (row_cnt != '0) begin
                        acc_en_c    = 1'b1;
                        row_cnt_nxt = row_cnt - RCW'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
